// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write tracker beside ID: stalls on RAW/WAW/long-unit hazards, flags forwarding-supplied operands.
// Stall is combinational from registered state + ID inputs; an issue becomes visible one cycle later.
module hazard_scoreboard #(
  parameter int LOAD_LAT = 1,
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [4:0] issue_rs_1,
  input  logic [4:0] issue_rs_2,
  input  logic [4:0] issue_rd,
  input  logic       issue_reg_write,
  input  logic       issue_is_load,
  input  logic       issue_is_long,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  output logic       stall,
  output logic       rs_1_pending,
  output logic       rs_2_pending,
  output logic [5:0] busy_count
);

  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_LAT);

  // Entry 0 exists only so x0 can be indexed; it is never set.
  logic [31:0]      busy;
  logic [CNT_W-1:0] cnt [32];
  logic [CNT_W-1:0] long_cnt;

  logic raw_1, raw_2, waw, structural, hazard, fire;
  logic set_en, clr_en, inc, dec;
  logic [CNT_W-1:0] new_cnt;

  assign raw_1      = (issue_rs_1 != 5'd0) && busy[issue_rs_1] && (cnt[issue_rs_1] != '0);
  assign raw_2      = (issue_rs_2 != 5'd0) && busy[issue_rs_2] && (cnt[issue_rs_2] != '0);
  assign waw        = issue_reg_write && (issue_rd != 5'd0) && busy[issue_rd] && (cnt[issue_rd] != '0);
  assign structural = issue_is_long && (long_cnt != '0);
  assign hazard     = issue_valid && (raw_1 || raw_2 || waw || structural);

  assign stall        = rst && hazard;
  assign rs_1_pending = rst && issue_valid && (issue_rs_1 != 5'd0) && busy[issue_rs_1] && (cnt[issue_rs_1] == '0);
  assign rs_2_pending = rst && issue_valid && (issue_rs_2 != 5'd0) && busy[issue_rs_2] && (cnt[issue_rs_2] == '0);

  assign fire    = issue_valid && !hazard;
  assign set_en  = fire && issue_reg_write && (issue_rd != 5'd0);
  assign clr_en  = wb_valid && (wb_rd != 5'd0);
  assign new_cnt = issue_is_long ? LONG_CNT : (issue_is_load ? LOAD_CNT : '0);

  // Issue wins a same-register collision with writeback, so that clear is not counted.
  assign inc = set_en && !busy[issue_rd];
  assign dec = clr_en && busy[wb_rd] && !(set_en && (issue_rd == wb_rd));

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy       <= '0;
      long_cnt   <= '0;
      busy_count <= '0;
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (set_en && (issue_rd == 5'(r))) begin
          busy[r] <= 1'b1;
          cnt[r]  <= new_cnt;
        end else if (clr_en && (wb_rd == 5'(r))) begin
          busy[r] <= 1'b0;
          cnt[r]  <= '0;
        end else if (cnt[r] != '0) begin
          cnt[r]  <= cnt[r] - CNT_W'(1);
        end
      end
      if (fire && issue_is_long) long_cnt <= LONG_CNT;
      else if (long_cnt != '0)   long_cnt <= long_cnt - CNT_W'(1);
      busy_count <= busy_count + {5'd0, inc} - {5'd0, dec};
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_reg_write, issue_is_load, issue_is_long, wb_valid;
  logic [4:0] issue_rs_1, issue_rs_2, issue_rd, wb_rd;
  logic       stall, rs_1_pending, rs_2_pending;
  logic [5:0] busy_count;

  typedef struct {
    int         id;
    logic       s;
    logic       p1;
    logic       p2;
    logic [5:0] bc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_id   = 0;

  hazard_scoreboard #(.LOAD_LAT(1), .LONG_LAT(4), .CNT_W(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .issue_rs_1      (issue_rs_1),
    .issue_rs_2      (issue_rs_2),
    .issue_rd        (issue_rd),
    .issue_reg_write (issue_reg_write),
    .issue_is_load   (issue_is_load),
    .issue_is_long   (issue_is_long),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .stall           (stall),
    .rs_1_pending    (rs_1_pending),
    .rs_2_pending    (rs_2_pending),
    .busy_count      (busy_count)
  );

  always #5 clk = ~clk;

  // One vector per cycle: drive just after the rising edge, expectation queued for the monitor.
  task automatic vec(input logic r, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic rw, input logic ld, input logic lg,
                     input logic wv, input logic [4:0] wr,
                     input logic es, input logic ep1, input logic ep2, input logic [5:0] ebc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; issue_valid = v; issue_rs_1 = rs1; issue_rs_2 = rs2; issue_rd = rd;
    issue_reg_write = rw; issue_is_load = ld; issue_is_long = lg; wb_valid = wv; wb_rd = wr;
    vec_id++;
    e.id = vec_id; e.s = es; e.p1 = ep1; e.p2 = ep2; e.bc = ebc;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (stall !== e.s) begin
        failures++;
        $display("FAIL stall vec%0d got=%b want=%b", e.id, stall, e.s);
      end
      checks++;
      if (rs_1_pending !== e.p1) begin
        failures++;
        $display("FAIL rs_1_pending vec%0d got=%b want=%b", e.id, rs_1_pending, e.p1);
      end
      checks++;
      if (rs_2_pending !== e.p2) begin
        failures++;
        $display("FAIL rs_2_pending vec%0d got=%b want=%b", e.id, rs_2_pending, e.p2);
      end
      checks++;
      if (busy_count !== e.bc) begin
        failures++;
        $display("FAIL busy_count vec%0d got=%0d want=%0d", e.id, busy_count, e.bc);
      end
    end
  end

  initial begin
    rst = 1'b0; issue_valid = 1'b0; issue_rs_1 = '0; issue_rs_2 = '0; issue_rd = '0;
    issue_reg_write = 1'b0; issue_is_load = 1'b0; issue_is_long = 1'b0; wb_valid = 1'b0; wb_rd = '0;
    repeat (2) @(posedge clk);

    //   rst v  rs1 rs2 rd rw ld lg wv wr    stall p1 p2 bc
    vec(1, 0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // reset state
    vec(1, 1, 0,  0,  5, 1, 0, 0, 0, 0,  0, 0, 0, 0);   // ALU x5
    vec(1, 1, 5,  0, 10, 0, 0, 0, 0, 0,  0, 1, 0, 1);   // read x5: forwarded
    vec(1, 1, 0,  0,  6, 1, 1, 0, 0, 0,  0, 0, 0, 1);   // load x6
    vec(1, 1, 0,  6, 11, 0, 0, 0, 0, 0,  1, 0, 0, 2);   // load-use stall
    vec(1, 1, 0,  6, 11, 0, 0, 0, 0, 0,  0, 0, 1, 2);   // issues, rs_2 forwarded
    vec(1, 1, 0,  0,  7, 1, 0, 1, 0, 0,  0, 0, 0, 2);   // long x7
    for (int i = 0; i < 4; i++)
      vec(1, 1, 0, 0, 8, 1, 0, 1, 0, 0,  1, 0, 0, 3);   // long x8 structural stall
    vec(1, 1, 0,  0,  8, 1, 0, 1, 0, 0,  0, 0, 0, 3);   // long x8 issues
    vec(1, 0, 0,  0,  0, 0, 0, 0, 1, 7,  0, 0, 0, 4);   // wb x7
    vec(1, 0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
    vec(1, 0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
    vec(1, 0, 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
    vec(1, 1, 0,  0,  9, 1, 0, 1, 0, 0,  0, 0, 0, 3);   // long x9
    for (int i = 0; i < 4; i++)
      vec(1, 1, 0, 0, 9, 1, 0, 0, 0, 0,  1, 0, 0, 4);   // WAW on x9
    vec(1, 1, 0,  0,  9, 1, 0, 0, 0, 0,  0, 0, 0, 4);   // ALU x9 issues, re-set of busy reg
    vec(1, 1, 9,  0,  9, 1, 0, 0, 1, 9,  0, 1, 0, 4);   // wb x9 + issue x9 collision
    vec(1, 1, 9,  0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 4);   // x9 still busy
    vec(1, 1, 0,  0, 12, 1, 1, 0, 0, 0,  0, 0, 0, 4);   // load x12
    vec(1, 1, 12, 0,  0, 0, 0, 0, 1, 12, 1, 0, 0, 5);   // same-cycle wb keeps stall
    vec(1, 1, 12, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 4);   // x12 retired
    vec(1, 1, 0,  0,  0, 1, 0, 1, 0, 0,  0, 0, 0, 4);   // long to x0
    vec(1, 1, 0,  0,  0, 1, 0, 0, 0, 0,  0, 0, 0, 4);   // write x0 never stalls
    vec(1, 1, 0,  0, 13, 1, 0, 1, 1, 0,  1, 0, 0, 4);   // long unit busy; wb x0 ignored
    vec(0, 1, 5,  6, 13, 1, 0, 1, 0, 0,  0, 0, 0, 4);   // reset mid long op
    vec(1, 1, 5,  6, 13, 1, 0, 1, 0, 0,  0, 0, 0, 0);   // all cleared, long x13 issues
    vec(1, 1, 13, 13, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1);   // RAW on x13 both sources
    vec(1, 1, 0,  0, 14, 1, 0, 0, 1, 13, 0, 0, 0, 1);   // set x14 + clear x13
    vec(1, 1, 14, 13, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1);   // net count unchanged

    begin : drain
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL drain left=%0d want=0", exp_q.size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
